apb_master_bridge: RTL and testbench

Single-outstanding APB requester that turns a simple valid/ready command port into compliant APB3 SETUP/ACCESS transfers on the 8-bit APB bus used across the APB verification environment. It drives `psel`/`penable`/`paddr`/`pwrite`/`pwdata` toward an APB completer and samples `pready`/`prdata`/`pslverr`. It returns one response per command, including a wait-state timeout abort. It is the initiator end of the same bus our slave-side benches monitor.

---
 rtl/apb_master_bridge.sv | 144 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: valid/ready command port in, SETUP/ACCESS
// transfers out, one response per command including a wait-state timeout abort.
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic       pclk,
  input  logic       prst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       psel,
  output logic       penable,
  output logic [7:0] paddr,
  output logic       pwrite,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic          psel_nxt, penable_nxt, pwrite_nxt;
  logic [7:0]    paddr_nxt, pwdata_nxt;
  logic          rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [7:0]    rsp_rdata_nxt;
  logic          cmd_ready_nxt, busy_nxt;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt       = state_r;
    cnt_nxt         = cnt_r;
    psel_nxt        = psel;
    penable_nxt     = penable;
    paddr_nxt       = paddr;
    pwrite_nxt      = pwrite;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt   = SETUP;
          paddr_nxt   = cmd_addr;
          pwrite_nxt  = cmd_write;
          pwdata_nxt  = cmd_write ? cmd_wdata : 8'h00;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = {CW{1'b0}};
      end
      ACCESS: begin
        if (pready) begin
          state_nxt       = IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = pwrite ? 8'h00 : prdata;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
        end else if (TMO_EN && (cnt_r == CNT_LAST)) begin
          state_nxt       = IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = 8'h00;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else if (cnt_r != CNT_MAX) begin
          cnt_nxt = cnt_r + CW'(1);
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
    cmd_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

  // State, wait counter and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= 8'h00;
      pwrite      <= 1'b0;
      pwdata      <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      busy        <= busy_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      paddr       <= paddr_nxt;
      pwrite      <= pwrite_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized
// transfers checked against a transaction-level model of the APB requester.
module tb_apb_master_bridge;

  localparam int TMO = 4;

  logic       pclk = 1'b0;
  logic       prst;
  logic       cmd_valid, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  apb_master_bridge #(.TIMEOUT(TMO)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // One command from issue to response. The completer raises pready after
  // 'waits' wait states; the model predicts ACCESS length and the response.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input int waits, input logic [7:0] rdata, input logic slverr,
                      input logic hold, input string tag, output time t_acc);
    int n_acc;
    logic tmo;
    logic [7:0] exp_pw;
    logic [9:0] exp_rsp;
    n_acc  = (waits < TMO) ? waits + 1 : TMO;
    tmo    = (waits >= TMO);
    exp_pw = wr ? wdata : 8'h00;
    exp_q.push_back({(tmo ? 1'b1 : slverr), tmo, ((wr || tmo) ? 8'h00 : rdata)});

    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_ready before issue: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'b0;
    @(posedge pclk);
    t_acc = $time;
    @(negedge pclk);
    cmd_valid = hold; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    n_checks++;
    if ({psel, penable, busy, cmd_ready, rsp_valid, paddr, pwrite, pwdata} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, addr, wr, exp_pw}) begin
      n_fail++;
      $display("FAIL %s setup: got sel=%b en=%b busy=%b rdy=%b rv=%b a=%h w=%b d=%h want 1 0 1 0 0 a=%h w=%b d=%h",
               tag, psel, penable, busy, cmd_ready, rsp_valid, paddr, pwrite, pwdata, addr, wr, exp_pw);
    end
    pready = 1'($urandom); prdata = 8'($urandom); pslverr = 1'($urandom);
    @(negedge pclk);
    for (int k = 0; k < n_acc; k++) begin
      n_checks++;
      if ({psel, penable, busy, rsp_valid, paddr, pwrite, pwdata} !==
          {1'b1, 1'b1, 1'b1, 1'b0, addr, wr, exp_pw}) begin
        n_fail++;
        $display("FAIL %s access[%0d]: got sel=%b en=%b busy=%b rv=%b a=%h w=%b d=%h want 1 1 1 0 a=%h w=%b d=%h",
                 tag, k, psel, penable, busy, rsp_valid, paddr, pwrite, pwdata, addr, wr, exp_pw);
      end
      pready  = (k == waits);
      prdata  = (k == waits) ? rdata : 8'($urandom);
      pslverr = (k == waits) ? slverr : 1'($urandom);
      @(negedge pclk);
    end
    pready = 1'b0;
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if ({psel, penable, busy, cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_rsp}) begin
      n_fail++;
      $display("FAIL %s response: got sel=%b en=%b busy=%b rdy=%b rv=%b err=%b tmo=%b rd=%h want 0 0 0 1 1 err=%b tmo=%b rd=%h",
               tag, psel, penable, busy, cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata,
               exp_rsp[9], exp_rsp[8], exp_rsp[7:0]);
    end
    n_checks++;
    if ({paddr, pwrite, pwdata} !== {addr, wr, exp_pw}) begin
      n_fail++;
      $display("FAIL %s bus hold after end: got a=%h w=%b d=%h want a=%h w=%b d=%h",
               tag, paddr, pwrite, pwdata, addr, wr, exp_pw);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge pclk);
    n_checks++;
    if ({rsp_valid, psel, penable, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL %s idle: got rv=%b sel=%b en=%b busy=%b rdy=%b want 0 0 0 0 1",
               tag, rsp_valid, psel, penable, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, psel, penable, paddr, pwrite, pwdata} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset values: got rdy=%b rv=%b rd=%h err=%b tmo=%b busy=%b sel=%b en=%b a=%h w=%b d=%h want all 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, psel, penable, paddr, pwrite, pwdata);
    end
    prst = 1'b0;
    idle_cycle("reset_release");
  endtask

  task automatic test_zero_wait_write();
    time t;
    xfer(1'b1, 8'h12, 8'hA5, 0, 8'h00, 1'b0, 1'b0, "zero_wait_write", t);
    idle_cycle("zero_wait_write_pulse");
  endtask

  task automatic test_wait_read();
    time t;
    xfer(1'b0, 8'h34, 8'h77, 2, 8'hC3, 1'b0, 1'b0, "wait_read", t);
    idle_cycle("wait_read_pulse");
  endtask

  task automatic test_slverr();
    time t;
    xfer(1'b1, 8'h5A, 8'h3C, 1, 8'h00, 1'b1, 1'b0, "slverr_write", t);
    xfer(1'b0, 8'h5B, 8'h00, 0, 8'h69, 1'b0, 1'b0, "after_slverr", t);
    idle_cycle("after_slverr_pulse");
  endtask

  task automatic test_timeout();
    time t;
    xfer(1'b0, 8'h80, 8'h00, 9, 8'hEE, 1'b0, 1'b0, "timeout_abort", t);
    idle_cycle("timeout_pulse");
    xfer(1'b0, 8'h81, 8'h00, TMO - 1, 8'h4D, 1'b1, 1'b0, "timeout_edge_ready", t);
    idle_cycle("timeout_edge_pulse");
  endtask

  task automatic test_reset_mid();
    time t;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h56; cmd_wdata = 8'h00;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    n_checks++;
    if ({psel, penable} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_mid access entry: got sel=%b en=%b want 1 1", psel, penable);
    end
    pready = 1'b0; prst = 1'b1;
    @(negedge pclk);
    n_checks++;
    if ({psel, penable, busy, rsp_valid, cmd_ready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid abort: got sel=%b en=%b busy=%b rv=%b rdy=%b want all 0",
               psel, penable, busy, rsp_valid, cmd_ready);
    end
    prst = 1'b0;
    idle_cycle("reset_mid_release");
    idle_cycle("reset_mid_quiet");
    xfer(1'b1, 8'h9C, 8'h1F, 1, 8'h00, 1'b0, 1'b0, "reset_mid_fresh", t);
    idle_cycle("reset_mid_fresh_pulse");
  endtask

  task automatic test_back_to_back();
    time t, prev;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(1'(i), 8'(8'h40 + i), 8'($urandom), 0, 8'($urandom), 1'(i == 5), 1'b1, "back_to_back", t);
      if (i > 0) begin
        n_checks++;
        if (t - prev !== 30) begin
          n_fail++;
          $display("FAIL back_to_back spacing[%0d]: got %0t want 30", i, t - prev);
        end
      end
      prev = t;
    end
    cmd_valid = 1'b0;
    idle_cycle("back_to_back_end");
  endtask

  task automatic test_random();
    time t;
    int gap;
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 2);
      xfer(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 5), 8'($urandom),
           1'($urandom), 1'($urandom), "random", t);
      cmd_valid = 1'b0;
      for (int g = 0; g < gap; g++) idle_cycle("random_gap");
    end
    idle_cycle("random_end");
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
